// File: rtl/crc_stream_parallel.sv
// rtl/crc_stream_parallel.sv - streaming CRC engine, P bits per beat, registered result handshake
module crc_stream_parallel #(
   parameter int               CRC_W  = 8,
   parameter logic [CRC_W-1:0] POLY   = 8'h07,
   parameter logic [CRC_W-1:0] INIT   = '0,
   parameter logic [CRC_W-1:0] XOROUT = '0,
   parameter int               P      = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [P-1:0]     in_data,
   input  logic             in_valid,
   input  logic             in_first,
   input  logic             in_last,
   input  logic             in_chk,
   output logic             in_ready,
   output logic [CRC_W-1:0] crc_out,
   output logic             crc_ok,
   output logic             crc_valid,
   input  logic             crc_ready,
   output logic             frame_err
);

   // DONE is never held: the result loads on the edge that accepts in_last
   // and the FSM lands back in IDLE on that same edge.
   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   state_t           state_next;
   logic [CRC_W-1:0] lfsr;
   logic [CRC_W-1:0] lfsr_next;
   logic [CRC_W-1:0] step;
   logic [P-1:0]     data_g;
   logic             fb;
   logic             mode;
   logic             mode_eff;
   logic             accept;
   logic             take;
   logic             load_out;
   logic             set_err;

   assign in_ready = !crc_valid || crc_ready;
   assign accept   = in_valid && in_ready;
   assign mode_eff = in_first ? in_chk : mode;

   // Unrolled serial Galois steps, MSB of the beat first.
   always_comb begin
      data_g = in_valid ? in_data : '0;
      step   = in_first ? INIT : lfsr;
      fb     = 1'b0;
      for (int i = P - 1; i >= 0; i--) begin
         fb   = step[CRC_W-1] ^ data_g[i];
         step = {step[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
      lfsr_next = step;
   end

   always_comb begin
      state_next = state;
      take       = 1'b0;
      load_out   = 1'b0;
      set_err    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (in_first) begin
                  take     = 1'b1;
                  load_out = in_last;
                  state_next = in_last ? IDLE : RUN;
               end else begin
                  set_err = 1'b1;
               end
            end
         end
         RUN: begin
            if (accept) begin
               take    = 1'b1;
               set_err = in_first;
               if (in_last) begin
                  load_out   = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         lfsr      <= INIT;
         mode      <= 1'b0;
         crc_out   <= '0;
         crc_ok    <= 1'b0;
         crc_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state <= state_next;
         if (take) begin
            lfsr <= lfsr_next;
            mode <= mode_eff;
         end
         if (set_err)
            frame_err <= 1'b1;
         // A reload in the same cycle as a pop keeps crc_valid high.
         if (load_out) begin
            crc_out   <= mode_eff ? lfsr_next : (lfsr_next ^ XOROUT);
            crc_ok    <= mode_eff && (lfsr_next == '0);
            crc_valid <= 1'b1;
         end else if (crc_ready) begin
            crc_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_crc_stream_parallel.sv
// tb/tb_crc_stream_parallel.sv - directed vector bench for crc_stream_parallel at P=8 and P=2
module tb_crc_stream_parallel;

   logic       clk = 1'b0;
   logic       reset;

   logic [7:0] d8_data;
   logic       d8_valid, d8_first, d8_last, d8_chk, d8_ready, d8_crc_ready;
   logic [7:0] d8_crc;
   logic       d8_ok, d8_cv, d8_err;

   logic [1:0] d2_data;
   logic       d2_valid, d2_first, d2_last, d2_chk, d2_ready, d2_crc_ready;
   logic [7:0] d2_crc;
   logic       d2_ok, d2_cv, d2_err;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   crc_stream_parallel #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOROUT(8'h00), .P(8)) dut8 (
      .clk(clk), .reset(reset), .in_data(d8_data), .in_valid(d8_valid), .in_first(d8_first),
      .in_last(d8_last), .in_chk(d8_chk), .in_ready(d8_ready), .crc_out(d8_crc), .crc_ok(d8_ok),
      .crc_valid(d8_cv), .crc_ready(d8_crc_ready), .frame_err(d8_err)
   );

   crc_stream_parallel #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOROUT(8'h00), .P(2)) dut2 (
      .clk(clk), .reset(reset), .in_data(d2_data), .in_valid(d2_valid), .in_first(d2_first),
      .in_last(d2_last), .in_chk(d2_chk), .in_ready(d2_ready), .crc_out(d2_crc), .crc_ok(d2_ok),
      .crc_valid(d2_cv), .crc_ready(d2_crc_ready), .frame_err(d2_err)
   );

   typedef struct {
      logic         lane8;
      logic         chk;
      int           len;
      logic [127:0] msg;
      logic [7:0]   exp_crc;
      logic         exp_ok;
   } vec_t;

   localparam logic [127:0] M9   = {72'h313233343536373839, 56'h0};
   localparam logic [127:0] M9F4 = {80'h313233343536373839F4, 48'h0};
   localparam logic [127:0] M9F5 = {80'h313233343536373839F5, 48'h0};
   localparam logic [127:0] M01  = {8'h01, 120'h0};
   localparam logic [127:0] M00  = 128'h0;

   vec_t tbl [8];

   function automatic vec_t mk(input logic lane8, input logic chk, input int len,
                               input logic [127:0] msg, input logic [7:0] c, input logic ok);
      vec_t v;
      v.lane8 = lane8; v.chk = chk; v.len = len; v.msg = msg; v.exp_crc = c; v.exp_ok = ok;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_res(input string tag, input logic lane8, input logic [7:0] c,
                            input logic ok, input logic err);
      if (lane8) begin
         check({tag, ".valid"}, 32'(d8_cv), 32'd1);
         check({tag, ".crc"}, 32'(d8_crc), 32'(c));
         check({tag, ".ok"}, 32'(d8_ok), 32'(ok));
         check({tag, ".err"}, 32'(d8_err), 32'(err));
      end else begin
         check({tag, ".valid"}, 32'(d2_cv), 32'd1);
         check({tag, ".crc"}, 32'(d2_crc), 32'(c));
         check({tag, ".ok"}, 32'(d2_ok), 32'(ok));
         check({tag, ".err"}, 32'(d2_err), 32'(err));
      end
   endtask

   task automatic idle_inputs();
      d8_valid = 1'b0; d8_first = 1'b0; d8_last = 1'b0; d8_chk = 1'b0; d8_data = 8'h00;
      d2_valid = 1'b0; d2_first = 1'b0; d2_last = 1'b0; d2_chk = 1'b0; d2_data = 2'b00;
   endtask

   // Drives one frame on the chosen lane; returns #1 after the edge accepting in_last.
   task automatic send_frame(input logic lane8, input logic chk, input int len, input logic [127:0] msg);
      logic [7:0] b;
      for (int i = 0; i < len; i++) begin
         b = msg[127-8*i -: 8];
         if (lane8) begin
            d8_valid = 1'b1; d8_data = b; d8_chk = chk;
            d8_first = (i == 0); d8_last = (i == len - 1);
            @(posedge clk); #1;
         end else begin
            for (int k = 0; k < 4; k++) begin
               d2_valid = 1'b1; d2_data = b[7-2*k -: 2]; d2_chk = chk;
               d2_first = (i == 0 && k == 0); d2_last = (i == len - 1 && k == 3);
               @(posedge clk); #1;
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      tbl[0] = mk(1'b1, 1'b0, 9,  M9,   8'hF4, 1'b0);
      tbl[1] = mk(1'b0, 1'b0, 9,  M9,   8'hF4, 1'b0);
      tbl[2] = mk(1'b0, 1'b0, 1,  M01,  8'h07, 1'b0);
      tbl[3] = mk(1'b1, 1'b1, 10, M9F4, 8'h00, 1'b1);
      tbl[4] = mk(1'b1, 1'b1, 10, M9F5, 8'h07, 1'b0);
      tbl[5] = mk(1'b1, 1'b0, 1,  M01,  8'h07, 1'b0);
      tbl[6] = mk(1'b0, 1'b1, 10, M9F4, 8'h00, 1'b1);
      tbl[7] = mk(1'b1, 1'b0, 1,  M00,  8'h00, 1'b0);

      idle_inputs();
      d8_crc_ready = 1'b1; d2_crc_ready = 1'b1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      check("rst.d8_valid", 32'(d8_cv), 32'd0);
      check("rst.d8_crc", 32'(d8_crc), 32'd0);
      check("rst.d8_ok", 32'(d8_ok), 32'd0);
      check("rst.d8_err", 32'(d8_err), 32'd0);
      check("rst.d8_ready", 32'(d8_ready), 32'd1);
      check("rst.d2_valid", 32'(d2_cv), 32'd0);
      check("rst.d2_crc", 32'(d2_crc), 32'd0);

      for (int v = 0; v < 8; v++) begin
         send_frame(tbl[v].lane8, tbl[v].chk, tbl[v].len, tbl[v].msg);
         check_res($sformatf("vec%0d", v), tbl[v].lane8, tbl[v].exp_crc, tbl[v].exp_ok, 1'b0);
      end

      // Backpressure: hold result, then pop together with a one-beat frame.
      @(posedge clk); #1;
      check("bp.pre_pop", 32'(d8_cv), 32'd0);
      d8_crc_ready = 1'b0;
      send_frame(1'b1, 1'b0, 9, M9);
      check_res("bp.first", 1'b1, 8'hF4, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("bp.hold%0d.ready", c), 32'(d8_ready), 32'd0);
         check($sformatf("bp.hold%0d.valid", c), 32'(d8_cv), 32'd1);
         check($sformatf("bp.hold%0d.crc", c), 32'(d8_crc), 32'hF4);
      end
      d8_crc_ready = 1'b1;
      #1 check("bp.ready_on_pop", 32'(d8_ready), 32'd1);
      d8_valid = 1'b1; d8_first = 1'b1; d8_last = 1'b1; d8_chk = 1'b0; d8_data = 8'h01;
      @(posedge clk); #1;
      idle_inputs();
      check_res("bp.reload", 1'b1, 8'h07, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("bp.drain", 32'(d8_cv), 32'd0);

      // Protocol errors: stray beat in IDLE, then in_first mid-frame.
      d8_valid = 1'b1; d8_data = 8'h55;
      @(posedge clk); #1;
      idle_inputs();
      check("perr.stray_err", 32'(d8_err), 32'd1);
      check("perr.stray_valid", 32'(d8_cv), 32'd0);
      d8_valid = 1'b1; d8_first = 1'b1; d8_data = 8'h31;
      @(posedge clk); #1;
      d8_first = 1'b0; d8_data = 8'h32;
      @(posedge clk); #1;
      idle_inputs();
      send_frame(1'b1, 1'b0, 9, M9);
      check_res("perr.restart", 1'b1, 8'hF4, 1'b0, 1'b1);

      // Reset mid-frame after 4 beats.
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         d8_valid = 1'b1; d8_first = (i == 0); d8_data = 8'hA0 + 8'(i);
         @(posedge clk); #1;
      end
      idle_inputs();
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      check("mrst.valid", 32'(d8_cv), 32'd0);
      check("mrst.err", 32'(d8_err), 32'd0);
      check("mrst.crc", 32'(d8_crc), 32'd0);
      @(posedge clk); #1;
      check("mrst.no_spurious", 32'(d8_cv), 32'd0);
      send_frame(1'b1, 1'b0, 9, M9);
      check_res("mrst.frame", 1'b1, 8'hF4, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
